// File: rtl/mul_issue_ctrl_if.sv
// Operand-issue and result-return handshake bundle for mul_issue_ctrl.
// slave is the controller's view, master the producer/consumer side.
interface mul_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [39:0]      in_a;
  logic [39:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [39:0]      out_c;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_c, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_c, out_tag
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/collect controller around a free-running MUL_LAT-stage limb multiplier.
// Credits (FIFO occupancy + in-flight) gate in_ready so captures can never overflow.
module mul_issue_ctrl #(
  parameter int MUL_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  mul_issue_ctrl_if.slave bus,
  output logic [7:0] mul_a0,
  output logic [7:0] mul_a1,
  output logic [7:0] mul_a2,
  output logic [7:0] mul_a3,
  output logic [7:0] mul_a4,
  output logic [7:0] mul_b0,
  output logic [7:0] mul_b1,
  output logic [7:0] mul_b2,
  output logic [7:0] mul_b3,
  output logic [7:0] mul_b4,
  input  logic [7:0] mul_c0,
  input  logic [7:0] mul_c1,
  input  logic [7:0] mul_c2,
  input  logic [7:0] mul_c3,
  input  logic [7:0] mul_c4,
  output logic       idle
);
  localparam int NUM_LANES = 5;
  localparam int VEC_W     = 8;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] c;
    logic [TAG_W-1:0]                tag;
  } res_t;

  logic [NUM_LANES-1:0][VEC_W-1:0] op_a, op_b, prod;
  logic [MUL_LAT:0]                vld_pipe;
  logic [TAG_W-1:0]                tag_pipe [MUL_LAT+1];
  res_t                            mem [FIFO_DEPTH];
  res_t                            head;
  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [CW-1:0]                   count, rsv, rsv_nxt;
  logic                            issue, push, pop, out_vld, in_ready_q;

  assign issue   = bus.in_valid & in_ready_q;
  assign push    = vld_pipe[MUL_LAT];
  assign out_vld = (count != '0);
  assign pop     = out_vld & bus.out_ready;
  assign prod    = {mul_c4, mul_c3, mul_c2, mul_c1, mul_c0};

  // operand registers hold between issues; the multiplier recomputes every cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_a <= '0;
      op_b <= '0;
    end else if (issue) begin
      op_a <= bus.in_a;
      op_b <= bus.in_b;
    end
  end

  assign mul_a0 = op_a[0];
  assign mul_a1 = op_a[1];
  assign mul_a2 = op_a[2];
  assign mul_a3 = op_a[3];
  assign mul_a4 = op_a[4];
  assign mul_b0 = op_b[0];
  assign mul_b1 = op_b[1];
  assign mul_b2 = op_b[2];
  assign mul_b3 = op_b[3];
  assign mul_b4 = op_b[4];

  // stage MUL_LAT lines up with the multiplier output of the matching issue
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      for (int i = 0; i <= MUL_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[MUL_LAT-1:0], issue};
      tag_pipe[0] <= issue ? bus.in_tag : '0;
      for (int i = 1; i <= MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {prod, tag_pipe[MUL_LAT]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    rsv_nxt = rsv;
    case ({issue, pop})
      2'b10:   rsv_nxt = rsv + CW'(1);
      2'b01:   rsv_nxt = rsv - CW'(1);
      default: ;
    endcase
  end

  // in_ready looks at next credits so it is a flop with no path from out_ready
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsv        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      rsv        <= rsv_nxt;
      in_ready_q <= (rsv_nxt < DEPTH_C);
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_vld;
  assign bus.out_c     = out_vld ? head.c   : '0;
  assign bus.out_tag   = out_vld ? head.tag : '0;
  assign idle          = (rsv == '0);
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: stand-in modular multiplier plus a transaction-queue
// reference model checked every cycle, with directed scenarios and a random phase.
module tb_mul_issue_ctrl;
  localparam int MUL_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 4;
  localparam logic [39:0] MOD = 40'hFF_FFFF_FFA9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] mul_a0, mul_a1, mul_a2, mul_a3, mul_a4;
  logic [7:0] mul_b0, mul_b1, mul_b2, mul_b3, mul_b4;
  logic [7:0] mul_c0, mul_c1, mul_c2, mul_c3, mul_c4;
  logic       idle;

  mul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  mul_issue_ctrl #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .mul_a0(mul_a0), .mul_a1(mul_a1), .mul_a2(mul_a2), .mul_a3(mul_a3), .mul_a4(mul_a4),
    .mul_b0(mul_b0), .mul_b1(mul_b1), .mul_b2(mul_b2), .mul_b3(mul_b3), .mul_b4(mul_b4),
    .mul_c0(mul_c0), .mul_c1(mul_c1), .mul_c2(mul_c2), .mul_c3(mul_c3), .mul_c4(mul_c4),
    .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] fmul(input logic [39:0] a, input logic [39:0] b);
    logic [79:0] p;
    p = {40'd0, a} * {40'd0, b};
    p = p % {40'd0, MOD};
    return p[39:0];
  endfunction

  function automatic logic [39:0] rand40();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[39:0];
  endfunction

  // free-running multiplier stand-in with MUL_LAT register stages
  logic [39:0] mstage [MUL_LAT];
  always @(posedge clk) begin
    mstage[0] <= fmul({mul_a4, mul_a3, mul_a2, mul_a1, mul_a0},
                      {mul_b4, mul_b3, mul_b2, mul_b1, mul_b0});
    for (int i = 1; i < MUL_LAT; i++) mstage[i] <= mstage[i-1];
  end
  assign {mul_c4, mul_c3, mul_c2, mul_c1, mul_c0} = mstage[MUL_LAT-1];

  typedef struct {
    logic [39:0]      c;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   dut_acc = 0;
  int   dut_pop = 0;
  bit   ready_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // model: an op is live from its issue edge until popped; its result is
  // visible MUL_LAT+1 edges after issue once it reaches the head
  task automatic step();
    bit   exp_rdy, exp_ov, fi, fo;
    exp_t nxt;
    exp_rdy = ready_en && (q.size() < FIFO_DEPTH);
    exp_ov  = (q.size() != 0) && (cyc >= q[0].rdy);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    chk("idle", 64'(idle), 64'(q.size() == 0));
    if (exp_ov) begin
      chk("out_c", 64'(bus.out_c), 64'(q[0].c));
      chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
    end
    if (bus.in_valid && bus.in_ready) dut_acc++;
    if (bus.out_valid && bus.out_ready) dut_pop++;
    fi = reset && bus.in_valid && exp_rdy;
    fo = reset && exp_ov && bus.out_ready;
    nxt.c   = fmul(bus.in_a, bus.in_b);
    nxt.tag = bus.in_tag;
    nxt.rdy = 0;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      q.delete();
      ready_en = 1'b0;
    end else begin
      ready_en = 1'b1;
      if (fo) void'(q.pop_front());
      if (fi) begin
        nxt.rdy = cyc + MUL_LAT + 1;
        q.push_back(nxt);
      end
    end
    #1;
  endtask

  task automatic rand_in();
    bus.in_a   = rand40();
    bus.in_b   = rand40();
    bus.in_tag = TAG_W'($urandom());
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(n < 100), 64'(1));
    step();
  endtask

  initial begin
    int lat, a0, p0, n;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_mul_a", 64'({mul_a4, mul_a3, mul_a2, mul_a1, mul_a0}), 64'(0));
    chk("rst_mul_b", 64'({mul_b4, mul_b3, mul_b2, mul_b1, mul_b0}), 64'(0));
    chk("rst_out_c", 64'(bus.out_c), 64'(0));
    chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
    reset = 1'b1;
    step();
    chk("ready_after_rst", 64'(bus.in_ready), 64'(1));

    // identity operand, latency from issue to out_valid
    bus.in_a = 40'h00_0000_0001; bus.in_b = 40'h12_3456_789A; bus.in_tag = 4'd3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("ident_latency", 64'(lat), 64'(3));
    chk("ident_c", 64'(bus.out_c), 64'h12_3456_789A);
    chk("ident_tag", 64'(bus.out_tag), 64'(3));
    drain();

    // streaming: a reservation lives MUL_LAT+2 edges, so in_ready follows the credit count
    bus.out_ready = 1'b1;
    a0 = dut_acc; p0 = dut_pop; n = 0;
    while (dut_acc - a0 < 16 && n < 100) begin
      rand_in();
      bus.in_valid = 1'b1;
      step();
      n++;
    end
    chk("stream_accepts", 64'(dut_acc - a0), 64'(16));
    drain();
    chk("stream_pops", 64'(dut_pop - p0), 64'(16));
    chk("stream_idle", 64'(idle), 64'(1));

    // backpressure: credits run out at FIFO_DEPTH
    bus.out_ready = 1'b0;
    a0 = dut_acc;
    repeat (8) begin
      rand_in();
      bus.in_valid = 1'b1;
      step();
    end
    chk("bp_accepts", 64'(dut_acc - a0), 64'(4));
    chk("bp_ready_low", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    p0 = dut_pop;
    repeat (8) step();
    chk("bp_pops", 64'(dut_pop - p0), 64'(4));
    rand_in();
    bus.in_valid = 1'b1;
    step();
    chk("bp_resume", 64'(dut_acc - a0), 64'(5));
    drain();

    // same-edge issue and pop with three credits taken
    bus.out_ready = 1'b0;
    a0 = dut_acc; n = 0;
    while (dut_acc - a0 < 3 && n < 20) begin
      rand_in();
      bus.in_valid = 1'b1;
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      step();
      n++;
    end
    chk("se_head_valid", 64'(bus.out_valid), 64'(1));
    rand_in();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    chk("se_pre_ready", 64'(bus.in_ready), 64'(1));
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("se_post_ready", 64'(bus.in_ready), 64'(1));
    chk("se_not_idle", 64'(idle), 64'(0));
    repeat (4) step();
    drain();

    // reset while two ops are in flight
    bus.out_ready = 1'b1;
    rand_in(); bus.in_valid = 1'b1; step();
    rand_in(); step();
    bus.in_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rr_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rr_idle", 64'(idle), 64'(1));
    chk("rr_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rr_mul_a", 64'({mul_a4, mul_a3, mul_a2, mul_a1, mul_a0}), 64'(0));
    repeat (6) step();
    rand_in(); bus.in_valid = 1'b1; step();
    drain();

    // zero operand with alternating tags
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_a = '0; bus.in_b = 40'hFF_FFFF_FFFF;
      bus.in_tag = (k % 2 == 1) ? 4'hF : 4'h0;
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      chk("zero_c", 64'(bus.out_c), 64'(0));
      chk("zero_tag", 64'(bus.out_tag), (k % 2 == 1) ? 64'hF : 64'h0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
    drain();

    // random traffic
    repeat (300) begin
      rand_in();
      bus.in_valid  = 1'($urandom() % 2);
      bus.out_ready = (($urandom() % 4) != 0);
      step();
    end
    drain();
    chk("final_idle", 64'(idle), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
